// File: rtl/serial_add.sv
// Digit-serial adder: WIDTH/DIGIT cycles per result, carry held between digits.
// Defining SERIAL_ADD_SUB_EN adds a 'sub' port that selects a + ~b + 1.
module serial_add #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] b_in_s;
    logic             cin_in_s;
    logic [DIGIT:0]   digit_s;
    logic             msb_cin_s;
    logic [WIDTH-1:0] sum_shift_s;

    // Operand conditioning: subtraction folds into addition of ~b with carry-in 1
    always_comb begin
        b_in_s   = b;
        cin_in_s = cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_in_s   = ~b;
            cin_in_s = 1'b1;
        end else begin
            b_in_s   = b;
            cin_in_s = cin;
        end
`endif
    end

    // One digit of the adder chain plus the carry into the digit's top bit
    always_comb begin
        digit_s   = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_r};
        msb_cin_s = digit_s[DIGIT-1] ^ a_r[DIGIT-1] ^ b_r[DIGIT-1];
        accept_s  = start && (state_r != RUN);
        last_s    = (state_r == RUN) && (cnt_r == CW'(N - 1));
    end

    // New digits enter sum from the top so the low digit ends at bit 0
    generate
        if (WIDTH > DIGIT) begin : g_shift
            assign sum_shift_s = {digit_s[DIGIT-1:0], sum_r[WIDTH-1:DIGIT]};
        end else begin : g_full
            assign sum_shift_s = digit_s[DIGIT-1:0];
        end
    endgenerate

    // Next-state logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand shift registers, carry, step counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b_in_s;
            carry_r <= cin_in_s;
            cnt_r   <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            a_r     <= a_r >> DIGIT;
            b_r     <= b_r >> DIGIT;
            sum_r   <= sum_shift_s;
            carry_r <= digit_s[DIGIT];
            cnt_r   <= cnt_r + CW'(1);
            if (last_s) begin
                cout_r <= digit_s[DIGIT];
                ovf_r  <= msb_cin_s ^ digit_s[DIGIT];
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add.sv
// Bench for serial_add: three geometries (8/1, 8/4, 4/2) against an arithmetic model.
module tb_serial_add;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start_v;
    logic [7:0] a_v [3];
    logic [7:0] b_v [3];
    logic       cin_v [3];
    logic       sub_v [3];
    logic [2:0] busy_v, done_v, cout_v, ovf_v;
    logic [7:0] sum0, sum1;
    logic [3:0] sum2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_add #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub_v[0]),
`endif
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum0), .cout(cout_v[0]), .ovf(ovf_v[0]));

    serial_add #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub_v[1]),
`endif
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .cout(cout_v[1]), .ovf(ovf_v[1]));

    serial_add #(.WIDTH(4), .DIGIT(2)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2][3:0]), .b(b_v[2][3:0]), .cin(cin_v[2]),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub_v[2]),
`endif
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum2), .cout(cout_v[2]), .ovf(ovf_v[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int inst);
        return (inst == 2) ? 4 : 8;
    endfunction

    function automatic int steps_of(input int inst);
        return (inst == 0) ? 8 : 2;
    endfunction

    function automatic logic [7:0] get_sum(input int inst);
        case (inst)
            0:       return sum0;
            1:       return sum1;
            default: return {4'h0, sum2};
        endcase
    endfunction

    // Reference: plain integer arithmetic, returns {ovf, cout, sum}
    function automatic logic [9:0] model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                         input logic cv, input logic sv);
        int   mask, bb, tot, s;
        logic co, ov;
        mask = (1 << w) - 1;
        bb   = sv ? ((~int'(bv)) & mask) : int'(bv);
        tot  = int'(av) + bb + (sv ? 1 : int'(cv));
        s    = tot & mask;
        co   = ((tot >> w) & 1) != 0;
        ov   = (av[w-1] == bb[w-1]) && (s[w-1] != av[w-1]);
        return {ov, co, 8'(s)};
    endfunction

    task automatic run_op(input int inst, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic sv, input int glitch);
        int         n, cyc, nbusy;
        logic       got_done;
        logic [9:0] exp;
        n   = steps_of(inst);
        exp = model(width_of(inst), av, bv, cv, sv);
        @(negedge clk);
        a_v[inst] = av; b_v[inst] = bv; cin_v[inst] = cv; sub_v[inst] = sv;
        start_v[inst] = 1'b1;
        @(posedge clk);
        #1 start_v[inst] = 1'b0;
        cyc = 0; nbusy = 0; got_done = 1'b0;
        while (!got_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == glitch) begin
                a_v[inst] = ~av; b_v[inst] = bv ^ 8'h5A; start_v[inst] = 1'b1;
            end else begin
                start_v[inst] = 1'b0;
            end
            if (done_v[inst]) got_done = 1'b1;
            else if (busy_v[inst]) nbusy++;
        end
        check("latency", cyc, n + 1);
        check("busy_cycles", nbusy, n);
        check("sum", get_sum(inst), exp[7:0]);
        check("cout", cout_v[inst], exp[8]);
        check("ovf", ovf_v[inst], exp[9]);
    endtask

    logic [7:0] qa [4];
    logic [7:0] qb [4];
    logic       qc [4];
    logic [9:0] bexp;
    int         bcyc;
    logic       bgot, seen;
    logic       rsub;

    initial begin
        rst_n = 1'b0;
        start_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            a_v[i] = 8'h00; b_v[i] = 8'h00; cin_v[i] = 1'b0; sub_v[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy_v[0], 1'b0);
        check("rst_done", done_v[0], 1'b0);
        check("rst_sum", sum0, 8'h00);
        check("rst_cout", cout_v[0], 1'b0);
        check("rst_ovf", ovf_v[0], 1'b0);

        // directed cases
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("sum_hold", sum0, 8'h80);
        run_op(0, 8'h80, 8'h80, 1'b1, 1'b0, 0);
        run_op(1, 8'h3C, 8'hC5, 1'b1, 1'b0, 0);

        // exhaustive 4-bit / 2-digit
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    run_op(2, 8'(x), 8'(y), c[0], 1'b0, 0);

        // random on both 8-bit geometries
        for (int i = 0; i < 120; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            rsub = 1'($urandom);
`else
            rsub = 1'b0;
`endif
            run_op(i % 2, 8'($urandom), 8'($urandom), 1'($urandom), rsub, 0);
        end

        // start during RUN must be ignored
        run_op(0, 8'h4D, 8'h29, 1'b0, 1'b0, 3);

        // start held high: a result every N+1 cycles with fresh operands
        for (int r = 0; r < 4; r++) begin
            qa[r] = 8'($urandom); qb[r] = 8'($urandom); qc[r] = 1'($urandom);
        end
        @(negedge clk);
        a_v[0] = qa[0]; b_v[0] = qb[0]; cin_v[0] = qc[0]; sub_v[0] = 1'b0;
        start_v[0] = 1'b1;
        for (int r = 0; r < 4; r++) begin
            bexp = model(8, qa[r], qb[r], qc[r], 1'b0);
            bcyc = 0; bgot = 1'b0;
            while (!bgot && bcyc < 40) begin
                @(negedge clk);
                bcyc++;
                if (done_v[0]) bgot = 1'b1;
            end
            check("b2b_period", bcyc, 9);
            check("b2b_sum", sum0, bexp[7:0]);
            check("b2b_cout", cout_v[0], bexp[8]);
            check("b2b_ovf", ovf_v[0], bexp[9]);
            if (r < 3) begin
                a_v[0] = qa[r+1]; b_v[0] = qb[r+1]; cin_v[0] = qc[r+1];
            end else begin
                start_v[0] = 1'b0;
            end
        end

        // reset in the middle of a run
        run_op(0, 8'h80, 8'h80, 1'b1, 1'b0, 0);
        @(negedge clk);
        a_v[0] = 8'hA5; b_v[0] = 8'h3C; cin_v[0] = 1'b1; start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_pre_rst", busy_v[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy_v[0], 1'b0);
        check("abort_done", done_v[0], 1'b0);
        check("abort_sum", sum0, 8'h00);
        check("abort_cout", cout_v[0], 1'b0);
        check("abort_ovf", ovf_v[0], 1'b0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[0]) seen = 1'b1;
        end
        check("no_done_after_abort", seen, 1'b0);
        run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 0);
        run_op(0, 8'h80, 8'h01, 1'b1, 1'b1, 0);
        run_op(1, 8'h10, 8'h20, 1'b0, 1'b1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_add.md
# serial_add

Parametrised multi-cycle adder built from a chain of DIGIT full-adder cells. The chain is reused over WIDTH/DIGIT clock cycles, with the carry held in a register between digits. It accepts WIDTH-bit operands under a start/busy/done handshake and returns the sum, the carry-out and the signed overflow. It is the sequential successor to the single-bit full adder, for datapaths where area matters more than latency.

## Interface
- WIDTH, 8: operand and sum width in bits; must be a multiple of DIGIT.
- DIGIT, 1: bits added per cycle; must be ≥1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new addition; sampled only while busy=0.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse: results valid.
- sum  output  WIDTH  result, low digit first internally.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- Clock is one domain. Reset is asynchronous and active-low. Ports are clk / rst_n.

## Operation
- The state machine has three states: IDLE, RUN and DONE. N = WIDTH/DIGIT steps.
- IDLE, or DONE, with start=1 at an edge:
  - a, b and cin are latched into shift registers and the carry register.
  - The step counter is cleared and the state moves to RUN.
- RUN, each edge:
  - Adds the low DIGIT bits of the A and B shift registers plus the carry register.
  - Shifts the resulting digit into sum from the top, then shifts A and B right by DIGIT.
  - Updates the carry register and increments the counter.
- RUN, on step N-1:
  - Captures cout.
  - Captures ovf from the carry into and out of bit WIDTH-1.
  - Moves to DONE.
- DONE lasts one cycle. With start=0 it returns to IDLE; with start=1 it accepts immediately and moves to RUN.
- busy = (state==RUN). done = (state==DONE).
- start while busy=1 is ignored and not queued.
- sum, cout and ovf hold their last results from done until the next accept. Contents of sum during RUN are undefined to consumers.
- Arithmetic is {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Operands are treated as unsigned for cout and as two's complement for ovf.

## Timing
- Reset (asynchronous assert; deassert synchronised externally):
  - state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; counter=0, carry=0.
- Reset asserted mid-RUN aborts the operation immediately; no done pulse is produced.
- Latency: with start accepted at edge k, busy is high from edge k to edge k+N. done is high for exactly the cycle following edge k+N.
- Throughput: one result per N+1 cycles. Back-to-back start held high gives done every N+1 cycles.
- With DIGIT==WIDTH: N=1, so busy lasts 1 cycle and done follows.
- The counter is ceil(log2(N+1)) bits wide and never wraps, because the state leaves RUN at N-1.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - Adds an input port sub (1 bit), captured on the accepting edge.
  - sub=1 computes a + ~b + 1; cin is ignored. cout=1 means no borrow; ovf is signed subtraction overflow.
  - sub=0 behaves as plain addition.
- SERIAL_ADD_SUB_EN undefined: no sub port; the block performs addition only.

## Test plan
- WIDTH=8, DIGIT=1, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0; done exactly 9 cycles after the accepting edge, busy high for 8 of them.
- WIDTH=8, DIGIT=1, a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80, cin=1 → sum=0x01, cout=1, ovf=1.
- WIDTH=8, DIGIT=4, a=0x3C, b=0xC5, cin=1 → sum=0x02, cout=1; done 3 cycles after accept. Exhaustive WIDTH=4, DIGIT=2: all 512 (a,b,cin) combinations match a+b+cin.
- start pulsed again 3 cycles into RUN with different operands → ignored; result is still from the first operands. start held high continuously → done every N+1 cycles with the new operands each time.
- rst_n driven low 4 cycles into an 8-step RUN → busy, done, sum, cout and ovf go to 0 asynchronously; no done pulse; a fresh start after release completes normally.
- SERIAL_ADD_SUB_EN, WIDTH=8: sub=1, a=0x05, b=0x07 → sum=0xFE, cout=0. Then sub=1, a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
